// File: rtl/crc32_d8_calc.sv
`default_nettype none
// ============================================================================
//  Module      : crc32_d8_calc
//  Description : Byte-serial Ethernet CRC-32 (IEEE 802.3, reflected) generator.
//                Absorbs one byte per clock while crc_en is high and presents
//                the running FCS on crc_result. The frame builder appends this
//                value LSB byte first.
//                Optional macro CRC32_D8_CHECK_EN adds the crc_ok residue
//                comparator output for receive-side frame checking.
//  Revision    : 1.0 - initial release
// ============================================================================
module crc32_d8_calc #(
    parameter logic [31:0] CRC_INIT   = 32'hFFFF_FFFF,
    parameter logic [31:0] CRC_XOROUT = 32'hFFFF_FFFF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  data,
    input  logic        crc_init,
    input  logic        crc_en,
    output logic [31:0] crc_result
`ifdef CRC32_D8_CHECK_EN
    ,
    output logic        crc_ok
`endif
);

    // Reflected form of 0x04C11DB7 (shift-right implementation)
    localparam logic [31:0] c_POLY_REFL = 32'hEDB8_8320;
    // Register value left after absorbing a good frame plus its own FCS
    localparam logic [31:0] c_RESIDUE   = 32'hDEBB_20E3;

    logic [31:0] r_crc_q;
    logic [7:0]  w_data;
    logic [31:0] w_crc_next;

    // Eight chained single-bit LFSR steps, data consumed LSB first; the loop
    // is fully unrolled into a flat XOR network.
    function automatic logic [31:0] f_next8(input logic [31:0] crc,
                                            input logic [7:0]  d);
        logic [31:0] c;
        logic        fb;
        c = crc;
        for (int i = 0; i < 8; i++) begin
            fb = c[0] ^ d[i];
            c  = (c >> 1) ^ (fb ? c_POLY_REFL : 32'h0000_0000);
        end
        return c;
    endfunction

    // Keep an undriven/X data bus out of the XOR network when not absorbing
    assign w_data = crc_en ? data : 8'h00;

    // Next register value if the current byte is absorbed
    always_comb begin
        w_crc_next = f_next8(r_crc_q, w_data);
    end

    // CRC register: rst > crc_init > crc_en > hold
    always_ff @(posedge clk) begin
        if (rst) begin
            r_crc_q <= CRC_INIT;
        end else if (crc_init) begin
            r_crc_q <= CRC_INIT;
        end else if (crc_en) begin
            r_crc_q <= w_crc_next;
        end
    end

    // Output is the register XORed with the final mask, no further reflection
    assign crc_result = r_crc_q ^ CRC_XOROUT;

`ifdef CRC32_D8_CHECK_EN
    // Good-frame detection once payload and appended FCS have been absorbed
    assign crc_ok = (r_crc_q == c_RESIDUE);
`endif

endmodule
`default_nettype wire

// File: tb/tb_crc32_d8_calc.sv
`default_nettype none
// ============================================================================
//  Module      : tb_crc32_d8_calc
//  Description : Self-checking bench for crc32_d8_calc. A driver applies one
//                set of inputs per clock and pushes the expected output into
//                a scoreboard queue; a monitor pops and compares each cycle.
//                Honours CRC32_D8_CHECK_EN for the crc_ok output.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_crc32_d8_calc;

    logic        clk;
    logic        rst;
    logic [7:0]  data;
    logic        crc_init;
    logic        crc_en;
    logic [31:0] crc_result;
`ifdef CRC32_D8_CHECK_EN
    logic        crc_ok;
`endif

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    typedef struct {
        logic [31:0] res;
        logic        ok;
    } exp_t;

    exp_t       sb_q[$];
    exp_t       mon_e;
    logic [7:0] msg[$];   // bytes absorbed since the last reset/init

    crc32_d8_calc dut (
        .clk        (clk),
        .rst        (rst),
        .data       (data),
        .crc_init   (crc_init),
        .crc_en     (crc_en),
        .crc_result (crc_result)
`ifdef CRC32_D8_CHECK_EN
        ,
        .crc_ok     (crc_ok)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: textbook software CRC-32 over a whole message
    function automatic logic [31:0] sw_crc32(input logic [7:0] m[$]);
        logic [31:0] c;
        c = 32'hFFFF_FFFF;
        foreach (m[k]) begin
            c = c ^ {24'h0, m[k]};
            for (int b = 0; b < 8; b++)
                c = c[0] ? ((c >> 1) ^ 32'hEDB8_8320) : (c >> 1);
        end
        return c ^ 32'hFFFF_FFFF;
    endfunction

    // One clock of stimulus; model is updated with the rules of the block
    task automatic step(input logic r, input logic i, input logic e,
                        input logic [7:0] d);
        exp_t x;
        rst      = r;
        crc_init = i;
        crc_en   = e;
        data     = d;
        @(posedge clk);
        if (r || i)  msg.delete();
        else if (e)  msg.push_back(d);
        x.res = sw_crc32(msg);
        x.ok  = ((x.res ^ 32'hFFFF_FFFF) == 32'hDEBB_20E3);
        sb_q.push_back(x);
        #1;
    endtask

    task automatic check_const(input string name, input logic [31:0] act,
                               input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: compare DUT output against the scoreboard every cycle
    always @(negedge clk) begin
        cyc++;
        if (sb_q.size() > 0) begin
            mon_e = sb_q.pop_front();
            checks++;
            if (crc_result !== mon_e.res) begin
                errors++;
                $display("FAIL crc_result @cycle %0d: got %h expected %h",
                         cyc, crc_result, mon_e.res);
            end
`ifdef CRC32_D8_CHECK_EN
            checks++;
            if (crc_ok !== mon_e.ok) begin
                errors++;
                $display("FAIL crc_ok @cycle %0d: got %b expected %b",
                         cyc, crc_ok, mon_e.ok);
            end
`endif
        end
    end

    logic [7:0] s123[9];
    logic [7:0] frame[13];
    int         flip;

    initial begin
        s123 = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39};
        rst = 1'b1; crc_init = 1'b0; crc_en = 1'b0; data = 8'h00;

        // Reset for 20 cycles, with random enable activity that must lose
        for (int k = 0; k < 20; k++)
            step(1'b1, 1'($urandom), 1'($urandom), 8'($urandom));
        check_const("reset_value", crc_result, 32'h0000_0000);
        // Idle with garbage on data
        for (int k = 0; k < 10; k++) step(1'b0, 1'b0, 1'b0, 8'($urandom));
        check_const("idle_hold", crc_result, 32'h0000_0000);

        // Check string
        step(1'b0, 1'b1, 1'b0, 8'h00);
        for (int k = 0; k < 9; k++) step(1'b0, 1'b0, 1'b1, s123[k]);
        check_const("check_123456789", crc_result, 32'hCBF4_3926);
        for (int k = 0; k < 4; k++) step(1'b0, 1'b0, 1'b0, 8'($urandom));
        check_const("check_hold", crc_result, 32'hCBF4_3926);

        // Single-byte vectors
        step(1'b0, 1'b1, 1'b0, 8'h00);
        step(1'b0, 1'b0, 1'b1, 8'h00);
        check_const("byte_00", crc_result, 32'hD202_EF8D);
        step(1'b0, 1'b1, 1'b0, 8'h00);
        step(1'b0, 1'b0, 1'b1, 8'h61);
        check_const("byte_61", crc_result, 32'hE8B7_BE43);

        // init beats en
        step(1'b0, 1'b1, 1'b1, 8'hAA);
        step(1'b0, 1'b0, 1'b0, 8'hAA);
        check_const("init_wins", crc_result, 32'h0000_0000);
        // rst mid-stream
        for (int k = 0; k < 5; k++) step(1'b0, 1'b0, 1'b1, 8'($urandom));
        step(1'b1, 1'b0, 1'b1, 8'h55);
        check_const("rst_midstream", crc_result, 32'h0000_0000);

        // Incrementing stream with a 3-cycle gap
        step(1'b0, 1'b1, 1'b0, 8'h00);
        for (int k = 1; k <= 30; k++) begin
            step(1'b0, 1'b0, 1'b1, 8'(k));
            if (k == 15)
                for (int g = 0; g < 3; g++) step(1'b0, 1'b0, 1'b0, 8'($urandom));
        end

        // Randomised traffic
        for (int k = 0; k < 400; k++)
            step(($urandom_range(0, 49) == 0), ($urandom_range(0, 19) == 0),
                 ($urandom_range(0, 3) != 0), 8'($urandom));

`ifdef CRC32_D8_CHECK_EN
        // Good frame: payload plus FCS LSB first
        frame = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38,
                  8'h39, 8'h26, 8'h39, 8'hF4, 8'hCB};
        step(1'b0, 1'b1, 1'b0, 8'h00);
        for (int k = 0; k < 13; k++) step(1'b0, 1'b0, 1'b1, frame[k]);
        check_const("crc_ok_good", {31'h0, crc_ok}, 32'h1);
        // Single bit error anywhere in the frame
        flip = $urandom_range(0, 103);
        frame[flip / 8][flip % 8] = ~frame[flip / 8][flip % 8];
        step(1'b0, 1'b1, 1'b0, 8'h00);
        for (int k = 0; k < 13; k++) step(1'b0, 1'b0, 1'b1, frame[k]);
        check_const("crc_ok_bad", {31'h0, crc_ok}, 32'h0);
`endif

        step(1'b0, 1'b0, 1'b0, 8'h00);
        @(negedge clk);
        @(negedge clk);
        checks++;
        if (sb_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: got %0d pending expected 0", sb_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
